// File: rtl/seq_scan_pkg.sv
// Shared definitions for the serial pattern scanner.
// Contents:
//   FRAME_W_DEF, PAT_W_DEF - default frame and pattern lengths in bits
//   state_t                - controller state encoding (IDLE / SHIFT / DONE)
package seq_scan_pkg;

    localparam int FRAME_W_DEF = 16;
    localparam int PAT_W_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_scan_if.sv
// Request/result bundle between a scan requester and seq_scan_ctrl.
// Signals:
//   start, data_in, pattern, overlap                  - request (master -> slave)
//   busy, done, bit_out, hit,
//   match_count, found, first_pos                     - status/result (slave -> master)
interface seq_scan_if
    import seq_scan_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int PAT_W   = PAT_W_DEF
) ();

    logic                       start;
    logic [FRAME_W-1:0]         data_in;
    logic [PAT_W-1:0]           pattern;
    logic                       overlap;
    logic                       busy;
    logic                       done;
    logic                       bit_out;
    logic                       hit;
    logic [$clog2(FRAME_W):0]   match_count;
    logic                       found;
    logic [$clog2(FRAME_W)-1:0] first_pos;

    modport master (
        output start, data_in, pattern, overlap,
        input  busy, done, bit_out, hit, match_count, found, first_pos
    );

    modport slave (
        input  start, data_in, pattern, overlap,
        output busy, done, bit_out, hit, match_count, found, first_pos
    );

endinterface

// File: rtl/seq_match.sv
// Serial pattern detector: keeps the last PAT_W-1 bits plus a fill count and
// flags a Mealy hit when {history, bit_in} equals the pattern.
// Ports:
//   clk, rst (async, active-low)
//   clear    - restart detection (history and fill to zero)
//   en       - a valid bit is present on bit_in this cycle
//   bit_in   - current serial bit
//   pattern  - target sequence, MSB is the oldest bit
//   overlap  - 1: a bit may contribute to several matches
//   hit      - combinational match flag, only while en
module seq_match
    import seq_scan_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             hit
);

    localparam int FILL_W = $clog2(PAT_W) + 1;

    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  window;
    logic              full;

    assign window = {hist, bit_in};
    assign full   = (fill >= FILL_W'(PAT_W - 1));
    assign hit    = en && full && (window == pattern);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            hist <= window[PAT_W-2:0];
            // Non-overlapping: emptying the fill count makes the next match
            // use only bits that arrive after this one.
            if (hit && !overlap) begin
                fill <= '0;
            end else if (!full) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame scanner: latches a frame, shifts it MSB first through seq_match and
// records how many matches occurred and where the first one completed.
// Ports:
//   clk, rst (async, active-low)
//   bus (seq_scan_if.slave) - start/data_in/pattern/overlap in;
//                             busy/done/bit_out/hit/match_count/found/first_pos out
//
// state | meaning
// IDLE  | waiting for start; results of the last scan held
// SHIFT | one frame bit presented per cycle, busy high
// DONE  | one-cycle done pulse, then back to IDLE
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int PAT_W   = PAT_W_DEF
) (
    input  logic      clk,
    input  logic      rst,
    seq_scan_if.slave bus
);

    localparam int IDX_W = $clog2(FRAME_W);
    localparam int CNT_W = $clog2(FRAME_W) + 1;

    state_t             state;
    logic               busy_q;
    logic               done_q;
    logic [IDX_W-1:0]   idx;
    logic [FRAME_W-1:0] shreg;
    logic [PAT_W-1:0]   pat_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   count_q;
    logic               found_q;
    logic [IDX_W-1:0]   first_q;
    logic               accept;
    logic               bit_cur;
    logic               hit;

    assign accept  = (state == IDLE) && bus.start;
    // busy_q is high exactly in SHIFT, so this forces bit_out low elsewhere.
    assign bit_cur = busy_q & shreg[FRAME_W-1];

    seq_match #(.PAT_W(PAT_W)) u_match (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .en      (busy_q),
        .bit_in  (bit_cur),
        .pattern (pat_q),
        .overlap (ovl_q),
        .hit     (hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx     <= '0;
            shreg   <= '0;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            count_q <= '0;
            found_q <= 1'b0;
            first_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state   <= SHIFT;
                        busy_q  <= 1'b1;
                        shreg   <= bus.data_in;
                        pat_q   <= bus.pattern;
                        ovl_q   <= bus.overlap;
                        idx     <= '0;
                        count_q <= '0;
                        found_q <= 1'b0;
                        first_q <= '0;
                    end
                end
                SHIFT: begin
                    if (hit) begin
                        count_q <= count_q + CNT_W'(1);
                        if (!found_q) begin
                            found_q <= 1'b1;
                            first_q <= idx;
                        end
                    end
                    shreg <= shreg << 1;
                    if (idx == IDX_W'(FRAME_W - 1)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.bit_out     = bit_cur;
    assign bus.hit         = hit;
    assign bus.match_count = count_q;
    assign bus.found       = found_q;
    assign bus.first_pos   = first_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
module tb_seq_scan_ctrl;

    localparam int FW = 16;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    seq_scan_if #(.FRAME_W(FW), .PAT_W(PW)) bus ();

    seq_scan_ctrl #(.FRAME_W(FW), .PAT_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] frame;
        logic [4:0]  cnt;
        logic        found;
        logic [3:0]  first;
        logic [15:0] mask;
    } exp_t;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  p;
        logic        o;
        exp_t        e;
        bit          hold;
        bit          scramble;
    } vec_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Window-based reference: window ending at bit index i is frame[18-i:15-i].
    function automatic exp_t model(input logic [15:0] d, input logic [3:0] p, input logic o);
        exp_t        e;
        int          last;
        logic [15:0] sh;
        e    = '{frame: d, cnt: 5'd0, found: 1'b0, first: 4'd0, mask: 16'd0};
        last = -PW;
        for (int i = PW - 1; i < FW; i++) begin
            sh = d >> (15 - i);
            if (sh[3:0] == p && (o || (i - last) >= PW)) begin
                e.mask[i] = 1'b1;
                e.cnt     = e.cnt + 5'd1;
                if (!e.found) begin
                    e.found = 1'b1;
                    e.first = 4'(i);
                end
                last = i;
            end
        end
        return e;
    endfunction

    // Caller must be at a negedge. Returns at a negedge with start low.
    task automatic run_scan(input logic [15:0] d, input logic [3:0] p, input logic o,
                            input exp_t e, input bit hold, input bit scramble);
        int          edges;
        int          busy_n;
        int          stray;
        int          lat;
        int          c;
        bit          done_seen;
        logic [15:0] mask;
        logic [15:0] bits;
        exp_t        got;
        bus.data_in = d;
        bus.pattern = p;
        bus.overlap = o;
        bus.start   = 1'b1;
        sb_q.push_back(e);
        edges = 0; busy_n = 0; stray = 0; lat = 0; c = 0;
        done_seen = 1'b0; mask = '0; bits = '0;
        @(posedge clk);
        edges++;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        if (scramble) begin
            bus.data_in = ~d;
            bus.pattern = ~p;
            bus.overlap = ~o;
        end
        while (!done_seen && c < 40) begin
            if (bus.busy) begin
                if (busy_n < FW) mask[busy_n] = bus.hit;
                bits = {bits[14:0], bus.bit_out};
                busy_n++;
            end else if (bus.hit || bus.bit_out) begin
                stray++;
            end
            if (bus.done) begin
                done_seen = 1'b1;
                lat = edges;
            end else begin
                @(posedge clk);
                edges++;
                @(negedge clk);
                c++;
            end
        end
        check("done_seen", 32'(done_seen), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("done_width", 32'(bus.done), 32'd0);
        check("no_restart", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        got = sb_q.pop_front();
        check("latency", 32'(lat), 32'd17);
        check("busy_width", 32'(busy_n), 32'd16);
        check("stray_out", 32'(stray), 32'd0);
        check("bit_seq", 32'(bits), 32'(got.frame));
        check("hit_mask", 32'(mask), 32'(got.mask));
        check("match_count", 32'(bus.match_count), 32'(got.cnt));
        check("found", 32'(bus.found), 32'(got.found));
        check("first_pos", 32'(bus.first_pos), 32'(got.first));
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{d: 16'hAAAA, p: 4'b1010, o: 1'b1, hold: 1'b0, scramble: 1'b0,
                   e: '{frame: 16'hAAAA, cnt: 5'd7, found: 1'b1, first: 4'd3, mask: 16'hAAA8}};
        tbl[1] = '{d: 16'hAAAA, p: 4'b1010, o: 1'b0, hold: 1'b0, scramble: 1'b1,
                   e: '{frame: 16'hAAAA, cnt: 5'd4, found: 1'b1, first: 4'd3, mask: 16'h8888}};
        tbl[2] = '{d: 16'hFFFF, p: 4'b1111, o: 1'b1, hold: 1'b0, scramble: 1'b0,
                   e: '{frame: 16'hFFFF, cnt: 5'd13, found: 1'b1, first: 4'd3, mask: 16'hFFF8}};
        tbl[3] = '{d: 16'hFFFF, p: 4'b1111, o: 1'b0, hold: 1'b0, scramble: 1'b0,
                   e: '{frame: 16'hFFFF, cnt: 5'd4, found: 1'b1, first: 4'd3, mask: 16'h8888}};
        tbl[4] = '{d: 16'h0000, p: 4'b1010, o: 1'b1, hold: 1'b0, scramble: 1'b0,
                   e: '{frame: 16'h0000, cnt: 5'd0, found: 1'b0, first: 4'd0, mask: 16'h0000}};
        tbl[5] = '{d: 16'hAAAA, p: 4'b1010, o: 1'b1, hold: 1'b1, scramble: 1'b0,
                   e: '{frame: 16'hAAAA, cnt: 5'd7, found: 1'b1, first: 4'd3, mask: 16'hAAA8}};

        bus.start   = 1'b0;
        bus.data_in = '0;
        bus.pattern = '0;
        bus.overlap = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bit_out", 32'(bus.bit_out), 32'd0);
        check("rst_hit", 32'(bus.hit), 32'd0);
        check("rst_count", 32'(bus.match_count), 32'd0);
        check("rst_found", 32'(bus.found), 32'd0);
        check("rst_first", 32'(bus.first_pos), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            run_scan(tbl[i].d, tbl[i].p, tbl[i].o, tbl[i].e, tbl[i].hold, tbl[i].scramble);
        end

        for (int r = 0; r < 4; r++) begin
            logic [15:0] d;
            logic [3:0]  p;
            logic        o;
            d = 16'($urandom);
            p = 4'($urandom_range(0, 15));
            o = 1'($urandom_range(0, 1));
            run_scan(d, p, o, model(d, p, o), 1'b0, 1'b0);
        end

        // Reset while bit index 8 is presented; three hits have been counted by then.
        bus.data_in = 16'hAAAA;
        bus.pattern = 4'b1010;
        bus.overlap = 1'b1;
        bus.start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        check("pre_rst_count", 32'(bus.match_count), 32'd3);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_bit_out", 32'(bus.bit_out), 32'd0);
        check("mid_rst_hit", 32'(bus.hit), 32'd0);
        check("mid_rst_count", 32'(bus.match_count), 32'd0);
        check("mid_rst_found", 32'(bus.found), 32'd0);
        check("mid_rst_first", 32'(bus.first_pos), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_scan(16'hAAAA, 4'b1010, 1'b1, model(16'hAAAA, 4'b1010, 1'b1), 1'b0, 1'b0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
